// File: rtl/game_flow_controller.sv
// Pac-Man frame sequencer: READY/PLAY/DYING/CLEAR/OVER flow with lives, pellets and fright timer.
// Optional GAME_FLOW_SCORE_EN adds a saturating 16-bit score output.
module game_flow_controller #(
   parameter int START_LIVES   = 3,
   parameter int PELLET_TOTAL  = 244,
   parameter int READY_FRAMES  = 120,
   parameter int DEATH_FRAMES  = 90,
   parameter int CLEAR_FRAMES  = 120,
   parameter int FRIGHT_FRAMES = 360
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       frame_tick,
   input  logic       start,
   input  logic       lose_game,
   input  logic       pellet_eaten,
   input  logic       power_eaten,
   output logic [2:0] game_state,
   output logic [2:0] lives,
   output logic [9:0] pellets_left,
   output logic       freeze,
   output logic       respawn,
   output logic       frightened,
   output logic [3:0] level
`ifdef GAME_FLOW_SCORE_EN
   ,
   output logic [15:0] score
`endif
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READY = 3'd1,
      S_PLAY  = 3'd2,
      S_DYING = 3'd3,
      S_CLEAR = 3'd4,
      S_OVER  = 3'd5
   } state_e;

   localparam logic [15:0] RDY_LAST = 16'(READY_FRAMES - 1);
   localparam logic [15:0] DTH_LAST = 16'(DEATH_FRAMES - 1);
   localparam logic [15:0] CLR_LAST = 16'(CLEAR_FRAMES - 1);
   localparam logic [2:0]  LIV_INIT = 3'(START_LIVES);
   localparam logic [9:0]  PEL_INIT = 10'(PELLET_TOTAL);
   localparam logic [9:0]  FRI_INIT = 10'(FRIGHT_FRAMES);

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  lives_q, lives_d;
   logic [9:0]  pel_q, pel_d;
   logic [3:0]  level_q, level_d;
   logic        freeze_q, freeze_d;
   logic        resp_q, resp_d;
   logic        fri_q, fri_d;
   logic [9:0]  fcnt_q, fcnt_d;
   logic        coll_q, coll_d;
   logic        start_q;

   logic        in_play;
   logic        coll_hit;
   logic [1:0]  pel_dec;
   logic [9:0]  pel_next;

`ifdef GAME_FLOW_SCORE_EN
   logic [15:0] score_q, score_d;
   logic        fcol_q, fcol_d;
   logic        fhit;
   logic [16:0] sc_add;
   logic [16:0] sc_sum;
`endif

   always_comb begin
      in_play  = (state_q == S_PLAY);
      pel_dec  = in_play ? ({1'b0, pellet_eaten} + {1'b0, power_eaten})
                         : 2'd0;
      pel_next = (pel_q > {8'd0, pel_dec}) ? (pel_q - {8'd0, pel_dec})
                                           : 10'd0;
      coll_hit = coll_q | (lose_game & ~fri_q);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = frame_tick ? (cnt_q + 16'd1) : cnt_q;
      lives_d = lives_q;
      pel_d   = pel_q;
      level_d = level_q;
      resp_d  = 1'b0;
      fri_d   = fri_q;
      fcnt_d  = fcnt_q;
      coll_d  = 1'b0;
`ifdef GAME_FLOW_SCORE_EN
      score_d = score_q;
      fcol_d  = 1'b0;
      fhit    = 1'b0;
      sc_add  = 17'd0;
      sc_sum  = 17'd0;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_READY;
               lives_d = LIV_INIT;
               pel_d   = PEL_INIT;
               level_d = 4'd0;
               resp_d  = 1'b1;
`ifdef GAME_FLOW_SCORE_EN
               score_d = 16'd0;
`endif
            end
         end
         S_READY: begin
            if (frame_tick && cnt_q == RDY_LAST) state_d = S_PLAY;
         end
         S_PLAY: begin
            pel_d  = pel_next;
            coll_d = frame_tick ? 1'b0 : coll_hit;
            // A power pellet reload beats a same-cycle countdown tick
            if (power_eaten) begin
               fri_d  = 1'b1;
               fcnt_d = FRI_INIT;
            end else if (frame_tick && fri_q) begin
               if (fcnt_q <= 10'd1) begin
                  fcnt_d = 10'd0;
                  fri_d  = 1'b0;
               end else begin
                  fcnt_d = fcnt_q - 10'd1;
               end
            end
`ifdef GAME_FLOW_SCORE_EN
            fhit   = lose_game & fri_q & ~fcol_q;
            fcol_d = frame_tick ? 1'b0 : (fcol_q | fhit);
            sc_add = (pellet_eaten ? 17'd10 : 17'd0)
                   + (power_eaten ? 17'd50 : 17'd0)
                   + (fhit ? 17'd200 : 17'd0);
            sc_sum = {1'b0, score_q} + sc_add;
            score_d = sc_sum[16] ? 16'hFFFF : sc_sum[15:0];
`endif
            if (frame_tick) begin
               if (pel_next == 10'd0) begin
                  state_d = S_CLEAR;
                  fri_d   = 1'b0;
                  fcnt_d  = 10'd0;
               end else if (coll_hit) begin
                  state_d = S_DYING;
                  lives_d = (lives_q == 3'd0) ? 3'd0 : (lives_q - 3'd1);
                  fri_d   = 1'b0;
                  fcnt_d  = 10'd0;
               end
            end
         end
         S_DYING: begin
            if (frame_tick && cnt_q == DTH_LAST) begin
               if (lives_q == 3'd0) begin
                  state_d = S_OVER;
               end else begin
                  state_d = S_READY;
                  resp_d  = 1'b1;
               end
            end
         end
         S_CLEAR: begin
            if (frame_tick && cnt_q == CLR_LAST) begin
               state_d = S_READY;
               pel_d   = PEL_INIT;
               level_d = (level_q == 4'd15) ? 4'd15 : (level_q + 4'd1);
               resp_d  = 1'b1;
            end
         end
         S_OVER: begin
            if (start && !start_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (state_d != state_q) cnt_d = 16'd0;
      freeze_d = (state_d != S_PLAY);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= 16'd0;
         lives_q  <= LIV_INIT;
         pel_q    <= PEL_INIT;
         level_q  <= 4'd0;
         freeze_q <= 1'b1;
         resp_q   <= 1'b0;
         fri_q    <= 1'b0;
         fcnt_q   <= 10'd0;
         coll_q   <= 1'b0;
         start_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         lives_q  <= lives_d;
         pel_q    <= pel_d;
         level_q  <= level_d;
         freeze_q <= freeze_d;
         resp_q   <= resp_d;
         fri_q    <= fri_d;
         fcnt_q   <= fcnt_d;
         coll_q   <= coll_d;
         start_q  <= start;
      end
   end

`ifdef GAME_FLOW_SCORE_EN
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         score_q <= 16'd0;
         fcol_q  <= 1'b0;
      end else begin
         score_q <= score_d;
         fcol_q  <= fcol_d;
      end
   end

   assign score = score_q;
`endif

   assign game_state   = state_q;
   assign lives        = lives_q;
   assign pellets_left = pel_q;
   assign freeze       = freeze_q;
   assign respawn      = resp_q;
   assign frightened   = fri_q;
   assign level        = level_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Scoreboard bench for game_flow_controller: directed stimulus queues expected
// outputs, a negedge monitor pops and compares them.
module tb_game_flow_controller;

   logic       Clk;
   logic       Reset_n;
   logic       frame_tick, start, lose_game, pellet_eaten, power_eaten;
   logic [2:0] game_state, lives;
   logic [9:0] pellets_left;
   logic       freeze, respawn, frightened;
   logic [3:0] level;
   logic [15:0] score_w;

   game_flow_controller #(
      .START_LIVES(2), .PELLET_TOTAL(4), .READY_FRAMES(2),
      .DEATH_FRAMES(2), .CLEAR_FRAMES(2), .FRIGHT_FRAMES(3)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
      .start(start), .lose_game(lose_game),
      .pellet_eaten(pellet_eaten), .power_eaten(power_eaten),
      .game_state(game_state), .lives(lives),
      .pellets_left(pellets_left), .freeze(freeze),
      .respawn(respawn), .frightened(frightened), .level(level)
`ifdef GAME_FLOW_SCORE_EN
      , .score(score_w)
`endif
   );

`ifndef GAME_FLOW_SCORE_EN
   assign score_w = 16'd0;
`endif

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      string      nm;
      int         due;
      logic [2:0] st;
      logic [2:0] lv;
      logic [9:0] pl;
      logic [3:0] lvl;
      logic       fz;
      logic       rs;
      logic       fr;
      logic       chk_sc;
      logic [15:0] sc;
   } exp_t;

   exp_t sb[$];
   exp_t r;
   int   mcyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;

   logic [2:0]  e_st, e_lv;
   logic [9:0]  e_pl;
   logic [3:0]  e_lvl;
   logic        e_fz, e_rs, e_fr, e_chk_sc;
   logic [15:0] e_sc;

   always @(negedge Clk) begin
      mcyc++;
      while (sb.size() > 0 && sb[0].due <= mcyc) begin
         r = sb.pop_front();
         n_vec++;
         if (game_state !== r.st || lives !== r.lv ||
             pellets_left !== r.pl || level !== r.lvl ||
             freeze !== r.fz || respawn !== r.rs ||
             frightened !== r.fr ||
             (r.chk_sc && score_w !== r.sc)) begin
            n_bad++;
            $display("FAIL %s: got st=%0d lv=%0d pl=%0d lvl=%0d fz=%0b rs=%0b fr=%0b sc=%0d want st=%0d lv=%0d pl=%0d lvl=%0d fz=%0b rs=%0b fr=%0b sc=%0d(chk %0b)",
                     r.nm, game_state, lives, pellets_left, level,
                     freeze, respawn, frightened, score_w,
                     r.st, r.lv, r.pl, r.lvl, r.fz, r.rs, r.fr,
                     r.sc, r.chk_sc);
         end
      end
   end

   task automatic set_e(input logic [2:0] st, input logic [2:0] lv,
                        input logic [9:0] pl, input logic [3:0] lvl,
                        input logic fz, input logic rs, input logic fr);
      e_st = st; e_lv = lv; e_pl = pl; e_lvl = lvl;
      e_fz = fz; e_rs = rs; e_fr = fr;
   endtask

   task automatic step(input logic ft, input logic s, input logic lg,
                       input logic pe, input logic pw, input string nm);
      exp_t x;
      frame_tick   = ft;
      start        = s;
      lose_game    = lg;
      pellet_eaten = pe;
      power_eaten  = pw;
      if (nm != "") begin
         x.nm = nm; x.due = mcyc + 1;
         x.st = e_st; x.lv = e_lv; x.pl = e_pl; x.lvl = e_lvl;
         x.fz = e_fz; x.rs = e_rs; x.fr = e_fr;
         x.chk_sc = e_chk_sc; x.sc = e_sc;
         sb.push_back(x);
      end
      @(negedge Clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset_n = 1'b0;
      frame_tick = 0; start = 0; lose_game = 0;
      pellet_eaten = 0; power_eaten = 0;
      e_chk_sc = 1'b0; e_sc = 16'd0;
      @(negedge Clk); #1;

      set_e(0, 2, 4, 0, 1, 0, 0); step(0, 0, 0, 0, 0, "reset");
      Reset_n = 1'b1;
      set_e(1, 2, 4, 0, 1, 1, 0); step(0, 1, 0, 0, 0, "start");
      e_rs = 0;                   step(0, 0, 0, 0, 0, "resp_1cyc");
      step(1, 0, 0, 0, 0, "ready_t1");
      set_e(2, 2, 4, 0, 0, 0, 0); step(1, 0, 0, 0, 0, "play");
      for (int i = 0; i < 4; i++) begin
         e_pl = 10'(3 - i);
         step(0, 0, 0, 1, 0, "pellet");
      end
      set_e(4, 2, 0, 0, 1, 0, 0); step(1, 0, 0, 0, 0, "clear");
      step(1, 0, 0, 0, 0, "clear_t1");
      set_e(1, 2, 4, 1, 1, 1, 0); step(1, 0, 0, 0, 0, "clear_ready");
      e_rs = 0;                   step(0, 0, 0, 0, 0, "ready_lvl1");
      step(1, 0, 0, 0, 0, "");
      set_e(2, 2, 4, 1, 0, 0, 0); step(1, 0, 0, 0, 0, "play2");
      step(0, 0, 1, 0, 0, "lose_play");
      set_e(3, 1, 4, 1, 1, 0, 0); step(1, 0, 0, 0, 0, "dying");
      step(1, 0, 0, 0, 0, "dying_t1");
      set_e(1, 1, 4, 1, 1, 1, 0); step(1, 0, 0, 0, 0, "dying_ready");
      e_rs = 0;                   step(0, 0, 0, 0, 0, "");
      step(1, 0, 0, 0, 0, "");
      set_e(2, 1, 4, 1, 0, 0, 0); step(1, 0, 0, 0, 0, "play3");

      set_e(2, 1, 3, 1, 0, 0, 1); step(0, 0, 0, 0, 1, "power");
      step(0, 0, 1, 0, 0, "fright_lose");
      step(1, 0, 0, 0, 0, "fright_t1");
      step(1, 0, 0, 0, 0, "fright_t2");
      e_pl = 2;                   step(0, 0, 0, 0, 1, "power_reload");
      step(1, 0, 0, 0, 0, "reload_t1");
      step(1, 0, 0, 0, 0, "reload_t2");
      e_fr = 0;                   step(1, 0, 0, 0, 0, "fright_end");

      e_pl = 1;                   step(0, 0, 0, 1, 0, "pellet_pre");
      e_pl = 0;                   step(0, 0, 1, 1, 0, "last_and_lose");
      set_e(4, 1, 0, 1, 1, 0, 0); step(1, 0, 0, 0, 0, "clear_wins");
      step(1, 0, 0, 0, 0, "");
      set_e(1, 1, 4, 2, 1, 1, 0); step(1, 0, 0, 0, 0, "clear_ready2");
      e_rs = 0;                   step(0, 0, 0, 0, 0, "");
      step(1, 0, 0, 0, 0, "");
      set_e(2, 1, 4, 2, 0, 0, 0); step(1, 0, 0, 0, 0, "play4");
      step(0, 0, 1, 0, 0, "");
      set_e(3, 0, 4, 2, 1, 0, 0); step(1, 0, 0, 0, 0, "dying_last");
      step(1, 0, 0, 0, 0, "");
      set_e(5, 0, 4, 2, 1, 0, 0); step(1, 0, 0, 0, 0, "over");
      step(0, 0, 1, 1, 0, "over_ignore");
      set_e(0, 0, 4, 2, 1, 0, 0); step(0, 1, 0, 0, 0, "over_idle");
      set_e(1, 2, 4, 0, 1, 1, 0); step(0, 1, 0, 0, 0, "new_game");
      e_rs = 0;                   step(0, 0, 0, 0, 0, "");
      step(1, 0, 0, 0, 0, "");
      set_e(2, 2, 4, 0, 0, 0, 0); step(1, 0, 0, 0, 0, "play5");
      step(0, 0, 1, 0, 0, "");
      set_e(3, 1, 4, 0, 1, 0, 0); step(1, 0, 0, 0, 0, "dying2");
      Reset_n = 1'b0;
      set_e(0, 2, 4, 0, 1, 0, 0); step(0, 0, 0, 0, 0, "reset_mid");
      Reset_n = 1'b1;

`ifdef GAME_FLOW_SCORE_EN
      e_chk_sc = 1'b1; e_sc = 16'd0;
      set_e(1, 2, 4, 0, 1, 1, 0); step(0, 1, 0, 0, 0, "sc_start");
      e_rs = 0;                   step(0, 0, 0, 0, 0, "");
      step(1, 0, 0, 0, 0, "");
      set_e(2, 2, 4, 0, 0, 0, 0); step(1, 0, 0, 0, 0, "sc_play");
      e_pl = 3; e_sc = 16'd10;    step(0, 0, 0, 1, 0, "sc_pellet");
      e_pl = 2; e_fr = 1;
      e_sc = 16'd60;              step(0, 0, 0, 0, 1, "sc_power");
      e_sc = 16'd260;             step(0, 0, 1, 0, 0, "sc_fcol");
      step(0, 0, 1, 0, 0, "sc_once");
`endif

      step(0, 0, 0, 0, 0, "");
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
